// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_ITER = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// Shared add/subtract step: multiply accumulate or divide trial subtraction.
module mdu_step #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum_c
);

    always_comb begin
        sum_c = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    mdu_state_t        state, state_n;
    mdu_op_t           op_q, op_q_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [WIDTH-1:0]  a_abs, a_abs_n, b_abs, b_abs_n;
    logic              sign_a, sign_a_n, sign_b, sign_b_n;
    logic              div_zero, div_zero_n;
    logic              busy_n, done_n;
    logic [WIDTH-1:0]  hi_n, lo_n;

    logic              is_div, is_signed_op, neg_a, neg_b;
    logic [WIDTH:0]    step_a, step_b, step_y;
    logic              trial_ok;
    logic [ACC_W-1:0]  prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix, dz_hi;

    // Divide uses the shifted remainder {rem, next dividend bit}; multiply adds to the upper half.
    assign is_div   = (op_q == DIV) || (op_q == DIVU);
    assign step_a   = is_div ? acc[ACC_W-1:WIDTH-1] : {1'b0, acc[ACC_W-1:WIDTH]};
    assign step_b   = {1'b0, (is_div ? b_abs : a_abs)};
    assign trial_ok = ~step_y[WIDTH];

    mdu_step #(.W(WIDTH + 1)) u_step (
        .a     (step_a),
        .b     (step_b),
        .sub   (is_div),
        .sum_c (step_y)
    );

    assign is_signed_op = (op == MULT) || (op == DIV);
    assign neg_a        = is_signed_op && rs_data[WIDTH-1];
    assign neg_b        = is_signed_op && rt_data[WIDTH-1];

    // Sign fixups applied in FIX; divide-by-zero rebuilds the original dividend.
    assign prod_fix = ((op_q == MULT) && (sign_a != sign_b)) ? -acc : acc;
    assign quo_fix  = (sign_a != sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sign_a ? -acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];
    assign dz_hi    = sign_a ? -a_abs : a_abs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= MULT;
            cnt      <= '0;
            acc      <= '0;
            a_abs    <= '0;
            b_abs    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state    <= state_n;
            op_q     <= op_q_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            a_abs    <= a_abs_n;
            b_abs    <= b_abs_n;
            sign_a   <= sign_a_n;
            sign_b   <= sign_b_n;
            div_zero <= div_zero_n;
            busy     <= busy_n;
            done     <= done_n;
            hi       <= hi_n;
            lo       <= lo_n;
        end
    end

    always_comb begin
        state_n    = state;
        op_q_n     = op_q;
        cnt_n      = cnt;
        acc_n      = acc;
        a_abs_n    = a_abs;
        b_abs_n    = b_abs;
        sign_a_n   = sign_a;
        sign_b_n   = sign_b;
        div_zero_n = div_zero;
        busy_n     = busy;
        done_n     = 1'b0;
        hi_n       = hi;
        lo_n       = lo;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        MULT, MULTU, DIV, DIVU: begin
                            op_q_n     = mdu_op_t'(op);
                            a_abs_n    = neg_a ? -rs_data : rs_data;
                            b_abs_n    = neg_b ? -rt_data : rt_data;
                            sign_a_n   = neg_a;
                            sign_b_n   = neg_b;
                            div_zero_n = ((op == DIV) || (op == DIVU)) && (rt_data == '0);
                            // Low half seeds the multiplier (mul) or the dividend (div).
                            acc_n      = {{WIDTH{1'b0}}, ((op == DIV) || (op == DIVU))
                                          ? (neg_a ? -rs_data : rs_data)
                                          : (neg_b ? -rt_data : rt_data)};
                            cnt_n      = '0;
                            busy_n     = 1'b1;
                            state_n    = RUN;
                        end
                        MTHI:    hi_n = rs_data;
                        MTLO:    lo_n = rs_data;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (is_div) begin
                    acc_n = {(trial_ok ? step_y[WIDTH-1:0] : acc[ACC_W-2:WIDTH-1]),
                             acc[WIDTH-2:0], trial_ok};
                end else begin
                    acc_n = {(acc[0] ? step_y : {1'b0, acc[ACC_W-1:WIDTH]}), acc[WIDTH-1:1]};
                end
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                if (!is_div) begin
                    hi_n = prod_fix[ACC_W-1:WIDTH];
                    lo_n = prod_fix[WIDTH-1:0];
                end else if (div_zero) begin
                    hi_n = dz_hi;
                    lo_n = '1;
                end else begin
                    hi_n = rem_fix;
                    lo_n = quo_fix;
                end
                cnt_n   = '0;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed and randomized checks of mdu_hilo against an arithmetic reference model.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_exec(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ohi,
                                             input logic [31:0] olo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: begin p = sa * sb; return p; end
            3'd1: begin p = ua * ub; return p; end
            3'd2, 3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd4:    return {a, olo};
            3'd5:    return {ohi, a};
            default: return {ohi, olo};
        endcase
    endfunction

    // Issue one op at the next edge and check it through completion; poke<0 disables the stray start.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke, input string tag);
        logic [63:0] e;
        logic [31:0] ohi, olo;
        int          cyc, busy_cnt;
        e   = ref_exec(o, a, b, m_hi, m_lo);
        ohi = m_hi;
        olo = m_lo;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        m_hi = e[63:32];
        m_lo = e[31:0];
        if (o > 3'd3) begin
            check({tag, " busy"}, 64'(busy), 64'd0);
            check({tag, " done"}, 64'(done), 64'd0);
            check({tag, " hilo"}, {hi, lo}, e);
            return;
        end
        check({tag, " busy_e0"}, 64'(busy), 64'd1);
        check({tag, " done_e0"}, 64'(done), 64'd0);
        busy_cnt = 1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == poke) begin
                start = 1'b1; op = 3'd1; rs_data = 32'd3; rt_data = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b1) check({tag, " hold"}, {hi, lo}, {ohi, olo});
        end
        check({tag, " latency"}, 64'(cyc), 64'd33);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " hilo"}, {hi, lo}, e);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20))
                                                        : -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          seen;
        logic [2:0]  ro;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst hilo", {hi, lo}, 64'd0);

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        check("done_clear", 64'(done), 64'd0);
        do_op(3'd0, -32'd3, 32'd5, -1, "mult_neg");
        check("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(3'd2, -32'd7, 32'd2, -1, "div_neg");
        check("div_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(3'd3, 32'd100, 32'd0, -1, "divu_zero");
        check("divu_zero const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        do_op(3'd2, -32'd5, 32'd0, -1, "div_zero");
        check("div_zero const", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
        do_op(3'd3, 32'd7, 32'd2, 10, "divu_poke");
        check("divu_poke const", {hi, lo}, 64'h0000_0001_0000_0003);
        do_op(3'd1, 32'd3, 32'd3, -1, "b2b_multu");
        check("b2b const", {hi, lo}, 64'h0000_0000_0000_0009);
        do_op(3'd4, 32'h1234_5678, 32'd0, -1, "mthi");
        do_op(3'd5, 32'h9ABC_DEF0, 32'd0, -1, "mtlo");
        check("mthi_mtlo const", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        do_op(3'd6, $urandom, $urandom, -1, "op6");
        do_op(3'd7, $urandom, $urandom, -1, "op7");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            do_op(ro, pick(), pick(), -1, "rand");
        end

        // Asynchronous abort in the middle of a multiply.
        start = 1'b1; op = 3'd1; rs_data = $urandom; rt_data = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("abort no_done", 64'(seen), 64'd0);
        do_op(3'd0, pick(), pick(), -1, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multi-cycle multiply/divide unit with the architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the 32-entry register bank and consumes the two read ports (rs → `rs_data`, rt → `rt_data`). It executes MULT/MULTU/DIV/DIVU iteratively over 32 cycles and services MTHI/MTLO writes in a single cycle. `hi`/`lo` are always visible for MFHI/MFLO writeback into the register bank.

## Interface

Parameters
- `WIDTH`, 32: operand/result width; iteration count equals `WIDTH`.

Ports
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled on a `clk` edge when `busy`=0.
- `op`  in  3  operation code, from the package: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 are ignored.
- `rs_data`  in  WIDTH  register-bank ReadData1 (multiplicand, dividend, or MTHI/MTLO source).
- `rt_data`  in  WIDTH  register-bank ReadData2 (multiplier or divisor).
- `busy`  out  1  an iterative operation is in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

- States are IDLE, RUN and FIX.
  - IDLE: accepts `start`.
  - RUN: performs 32 iterations, tracked by a 5-bit counter running 0..31.
  - FIX: applies the sign/zero fixup, writes HI/LO and returns to IDLE.
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- `start` with MULT/MULTU/DIV/DIVU in IDLE:
  - latch |rs| and |rt|; signed ops take the absolute value, unsigned ops pass the operand through;
  - latch the sign flags and a `div_zero` flag (`rt_data`==0, division ops only);
  - go to RUN.
- `start` with MTHI/MTLO in IDLE: write `rs_data` into `hi`/`lo` at that edge; stay in IDLE; `busy` and `done` are not asserted.
- `start` with `op` 6–7: ignored.
- `start` while `busy`=1: ignored. The latched operands are unaffected.
- Multiply: shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - FIX: negate the 64-bit product if sign(rs)≠sign(rt), for MULT only.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division with a 33-bit partial remainder, one quotient bit per cycle.
  - FIX for DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero: LO=0xFFFFFFFF and HI=`rs_data` as latched, for both DIV and DIVU. No sign fixup is applied.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap is raised.
- All arithmetic is modulo 2^WIDTH (or 2^2WIDTH for the product); no overflow flags exist.

## Timing

- E0 is the edge sampling `start`:
  - `busy`=1 after E0;
  - RUN occupies E1..E32;
  - FIX at E33 updates `hi`/`lo`, sets `done`=1 and `busy`=0;
  - `done` clears at E34.
- Latency: `hi`/`lo` and `done` are visible 33 cycles after the start edge.
- During RUN, `hi`/`lo` hold their previous values. The register bank may read them freely until `done`.
- Back-to-back: `start` may be asserted in the `done` cycle, because `busy`=0 there. It is accepted at E34 and `done` still drops at E34.
- MTHI/MTLO take effect at E0; the written value is readable in the next cycle.
- Reset mid-operation: asynchronous abort to the reset values. No `done` is produced for the aborted operation.
- Operand changes after E0 have no effect on the result.

## Structure

- Package `mdu_pkg` holds:
  - the `op` encodings as a 3-bit enum `mdu_op_t`;
  - the state enum `mdu_state_t` {IDLE, RUN, FIX};
  - `MDU_ITER`=32.
- One sub-module, `mdu_step`: combinational 33-bit add/subtract step shared by the multiply accumulate and the divide trial subtraction. The FSM, counter and HI/LO registers stay in `mdu_hilo`.

## Test plan

- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles `done`=1, `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for exactly 33 cycles.
- MULT −3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 100/0 → `lo`=0xFFFFFFFF, `hi`=0x00000064. DIV −5/0 → `lo`=0xFFFFFFFF, `hi`=0xFFFFFFFB.
- Repeated requests:
  - DIVU 7/2, with a second `start` (MULTU 3×3) pulsed at cycle 10 → ignored; result `lo`=3, `hi`=1.
  - MULTU 3×3 then issued in the `done` cycle → accepted; `hi`=0, `lo`=9 at 33 cycles later.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → `hi`/`lo` updated at each edge; `busy` and `done` stay 0.
- `rst_n` low at cycle 10 of a MULTU → `busy`, `done`, `hi`, `lo` all 0 immediately. No `done` pulse afterwards, and a new request after release completes normally.
